// File: rtl/clk_div_pkg.sv
// Shared types and default sizing for the multi-channel clock divider.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN1 = 2'd1,
        ST_RUN2 = 2'd2
    } step_st_e;

    localparam int CNT_W_DEF       = 21;
    localparam int DEFAULT_DIV_DEF = 250000;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, shadow/active divisor, single-step FSM,
// registered 50% output and terminal-count tick.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             step,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    output logic             clk_out,
    output logic             tick,
    output logic             stepping
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_sh_q, div_sh_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             stepping_q, stepping_d;
    step_st_e         st_q, st_d;
    logic             running;
    logic             term;

    always_comb begin
        running    = en || stepping_q;
        // >= rather than == so a divisor shrunk below cnt fires at once
        term       = running && (cnt_q >= div_act_q);
        cnt_d      = cnt_q;
        clk_out_d  = clk_out_q;
        div_sh_d   = wr ? wr_val : div_sh_q;
        div_act_d  = div_act_q;
        tick_d     = term;
        st_d       = st_q;

        if (term) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            div_act_d = wr ? wr_val : div_sh_q;
        end else if (running) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (wr) begin
            div_act_d = wr_val;
        end

        case (st_q)
            ST_IDLE: if (step && !en) st_d = ST_RUN1;
            ST_RUN1: if (en) st_d = ST_IDLE; else if (term) st_d = ST_RUN2;
            ST_RUN2: if (en || term) st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
        stepping_d = (st_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            div_sh_q   <= DIV_RST;
            div_act_q  <= DIV_RST;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            stepping_q <= 1'b0;
            st_q       <= ST_IDLE;
        end else begin
            cnt_q      <= cnt_d;
            div_sh_q   <= div_sh_d;
            div_act_q  <= div_act_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            stepping_q <= stepping_d;
            st_q       <= st_d;
        end
    end

    assign clk_out  = clk_out_q;
    assign tick     = tick_q;
    assign stepping = stepping_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock-enable / divided-clock generator: NUM_CH independent
// channels sharing only the divisor write decode.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int  NUM_CH      = 2,
    parameter int  CNT_W       = CNT_W_DEF,
    parameter int  DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] step,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] stepping
);

    logic [NUM_CH-1:0] wr_stb;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // out-of-range div_ch matches no index, so it is dropped here
        assign wr_stb[i] = div_wr && (div_ch == CH_W'(i));

        clk_div_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .step     (step[i]),
            .wr       (wr_stb[i]),
            .wr_val   (div_val),
            .clk_out  (clk_out[i]),
            .tick     (tick[i]),
            .stepping (stepping[i])
        );
    end

endmodule
